// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops plus an iterative shift-add unsigned multiply.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             carry
);

    localparam logic [3:0] OP_SLT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_next;
    logic               accept, load_single, mul_done;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, prod_sum, mul_addend;

    logic [WIDTH-1:0]   b_op;
    logic               sub_mode;
    logic [WIDTH:0]     sum_ext;
    logic               add_carry, add_ovf;
    logic [WIDTH-1:0]   res;
    logic               res_ovf, res_carry;

    assign in_ready = reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Subtract and slt share the adder as A + ~B + 1.
    assign sub_mode  = (control == OP_SUB) || (control == OP_SLT);
    assign b_op      = sub_mode ? ~B : B;
    assign sum_ext   = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_mode};
    assign add_carry = sum_ext[WIDTH];
    assign add_ovf   = (sum_ext[WIDTH-1] ^ A[WIDTH-1] ^ b_op[WIDTH-1]) ^ add_carry;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        res       = A;
        res_ovf   = 1'b0;
        res_carry = 1'b0;
        case (control)
            OP_ADD, OP_SUB: begin
                res       = sum_ext[WIDTH-1:0];
                res_ovf   = add_ovf;
                res_carry = add_carry;
            end
            OP_AND: res = A & B;
            OP_OR:  res = A | B;
            OP_NOR: res = ~(A | B);
            OP_XOR: res = A ^ B;
            OP_SLT: begin
                res    = '0;
                res[0] = sum_ext[WIDTH-1] ^ add_ovf;
            end
            default: res = A;
        endcase
    end

    // Counter walks the multiplier from MSB down to bit 0; the last step lands directly in out.
    assign mul_addend = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;
    assign prod_sum   = prod + mul_addend;

    always_comb begin
        state_next  = state;
        load_single = 1'b0;
        mul_done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (control == OP_MULU) state_next  = MUL;
                    else                    load_single = 1'b1;
                end
            end
            MUL: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                    mul_done   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: operand, counter and product registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clock) begin
        if (accept && control == OP_MULU) begin
            a_q  <= A;
            b_q  <= B;
            cnt  <= CNT_INIT;
            prod <= '0;
        end else if (state == MUL) begin
            prod <= prod_sum;
            cnt  <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
        end else if (load_single) begin
            out_valid <= 1'b1;
            out       <= res;
            overflow  <= res_ovf;
            zero      <= (res == '0);
            negative  <= res[WIDTH-1];
            carry     <= res_carry;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            out       <= prod_sum[WIDTH-1:0];
            overflow  <= |prod_sum[2*WIDTH-1:WIDTH];
            zero      <= (prod_sum[WIDTH-1:0] == '0);
            negative  <= prod_sum[WIDTH-1];
            carry     <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: a WIDTH=32 instance for most scenarios
// and a WIDTH=8 instance for the short multiply.
module tb_alu_seq;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // WIDTH=32 instance
    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, o32;
    logic [3:0]  c32 = '0;
    logic        ovf32, zr32, ng32, cy32;
    logic [3:0]  f32;  // {overflow, zero, negative, carry}
    assign f32 = {ovf32, zr32, ng32, cy32};

    // WIDTH=8 instance
    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, o8;
    logic [3:0]  c8 = '0;
    logic        ovf8, zr8, ng8, cy8;
    logic [3:0]  f8;
    assign f8 = {ovf8, zr8, ng8, cy8};

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(32)) u32 (
        .clock(clock), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .control(c32), .out_valid(ov32), .out_ready(or32),
        .out(o32), .overflow(ovf32), .zero(zr32), .negative(ng32), .carry(cy32)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .clock(clock), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .control(c8), .out_valid(ov8), .out_ready(or8),
        .out(o8), .overflow(ovf8), .zero(zr8), .negative(ng8), .carry(cy8)
    );

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        iv32 = 1'b1;
        a32  = a;
        b32  = b;
        c32  = c;
    endtask

    // Issue one single-cycle op and compare result and flags one edge later.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [31:0] exp_out, input logic [3:0] exp_f);
        drive32(a, b, c);
        checks++;
        if (ir32 !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready got %b expected 1", name, ir32);
        end
        step();
        iv32 = 1'b0;
        checks++;
        if (ov32 !== 1'b1 || o32 !== exp_out || f32 !== exp_f) begin
            errors++;
            $display("FAIL %s got valid=%b out=%h f=%b expected valid=1 out=%h f=%b",
                     name, ov32, o32, f32, exp_out, exp_f);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({ov32, o32, f32, ir32} !== {1'b0, 32'h0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got valid=%b out=%h f=%b in_ready=%b expected 0/0/0000/0",
                     ov32, o32, f32, ir32);
        end
        reset = 1'b1;
        step();
        checks++;
        if (ir32 !== 1'b1 || ir8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got %b/%b expected 1/1", ir32, ir8);
        end
    endtask

    task automatic test_arith();
        or32 = 1'b1;
        run_op("add_ovf",    32'h7FFFFFFF, 32'h1,        4'b0010, 32'h80000000, 4'b1010);
        run_op("add_carry",  32'hFFFFFFFF, 32'h1,        4'b0010, 32'h00000000, 4'b0101);
        run_op("sub_equal",  32'h12345678, 32'h12345678, 4'b0011, 32'h00000000, 4'b0101);
        run_op("sub_borrow", 32'h1,        32'h2,        4'b0011, 32'hFFFFFFFF, 4'b0010);
        run_op("sub_ovf",    32'h80000000, 32'h1,        4'b0011, 32'h7FFFFFFF, 4'b1001);
    endtask

    task automatic test_slt();
        run_op("slt_neg1",   32'hFFFFFFFF, 32'h1,        4'b0001, 32'h1, 4'b0000);
        run_op("slt_minmax", 32'h80000000, 32'h7FFFFFFF, 4'b0001, 32'h1, 4'b0000);
        run_op("slt_false",  32'h5,        32'h3,        4'b0001, 32'h0, 4'b0100);
        run_op("slt_maxmin", 32'h7FFFFFFF, 32'h80000000, 4'b0001, 32'h0, 4'b0100);
    endtask

    task automatic test_logic();
        run_op("and",  32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'hF000F000, 4'b0010);
        run_op("or",   32'hF0F0F0F0, 32'hFF00FF00, 4'b0101, 32'hFFF0FFF0, 4'b0010);
        run_op("nor",  32'hF0F0F0F0, 32'hFF00FF00, 4'b0110, 32'h000F000F, 4'b0000);
        run_op("xor",  32'hF0F0F0F0, 32'hFF00FF00, 4'b0111, 32'h0FF00FF0, 4'b0000);
        run_op("pass0", 32'h80000001, 32'hFFFFFFFF, 4'b0000, 32'h80000001, 4'b0010);
        run_op("passF", 32'h00000000, 32'h12345678, 4'b1111, 32'h00000000, 4'b0100);
    endtask

    // Counts edges after accept until out_valid, bounded; in_ready must stay low meanwhile.
    task automatic test_mulu8();
        int n;
        bit ready_seen;
        or8 = 1'b1;
        iv8 = 1'b1; a8 = 8'h10; b8 = 8'h11; c8 = 4'b1000;
        step();
        iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        n = 0;
        ready_seen = 1'b0;
        while (ov8 !== 1'b1 && n < 40) begin
            if (ir8 !== 1'b0) ready_seen = 1'b1;
            step();
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL mulu8_latency got %0d edges expected 8", n);
        end
        checks++;
        if (ready_seen) begin
            errors++;
            $display("FAIL mulu8_in_ready got 1 during MUL expected 0");
        end
        checks++;
        if (o8 !== 8'h10 || f8 !== 4'b1000) begin
            errors++;
            $display("FAIL mulu8_result got out=%h f=%b expected out=10 f=1000", o8, f8);
        end
        step();
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL mulu8_consume got out_valid=%b expected 0", ov8);
        end
    endtask

    task automatic test_mulu32();
        int n;
        drive32(32'h00001234, 32'h00000010, 4'b1000);
        step();
        iv32 = 1'b0;
        n = 0;
        while (ov32 !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (n != 32 || o32 !== 32'h00012340 || f32 !== 4'b0000) begin
            errors++;
            $display("FAIL mulu32 got edges=%0d out=%h f=%b expected edges=32 out=00012340 f=0000",
                     n, o32, f32);
        end
        step();
    endtask

    task automatic test_back_pressure();
        bit unstable;
        or32 = 1'b0;
        drive32(32'h3, 32'h4, 4'b0010);
        step();
        drive32(32'hFF, 32'h0F, 4'b0111);
        checks++;
        if (ov32 !== 1'b1 || o32 !== 32'h7) begin
            errors++;
            $display("FAIL bp_add got valid=%b out=%h expected valid=1 out=00000007", ov32, o32);
        end
        unstable = 1'b0;
        repeat (3) begin
            if (ir32 !== 1'b0 || ov32 !== 1'b1 || o32 !== 32'h7 || f32 !== 4'b0000) unstable = 1'b1;
            step();
        end
        checks++;
        if (unstable) begin
            errors++;
            $display("FAIL bp_hold got in_ready=%b valid=%b out=%h f=%b expected 0/1/00000007/0000",
                     ir32, ov32, o32, f32);
        end
        or32 = 1'b1;
        #1;
        checks++;
        if (ir32 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release in_ready got %b expected 1", ir32);
        end
        step();
        iv32 = 1'b0;
        checks++;
        if (ov32 !== 1'b1 || o32 !== 32'hF0) begin
            errors++;
            $display("FAIL bp_xor got valid=%b out=%h expected valid=1 out=000000F0", ov32, o32);
        end
        step();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got out_valid=%b expected 0", ov32);
        end
    endtask

    task automatic test_back_to_back();
        or32 = 1'b1;
        run_op("b2b_add", 32'h1,  32'h2,  4'b0010, 32'h3,  4'b0000);
        run_op("b2b_or",  32'h10, 32'h01, 4'b0101, 32'h11, 4'b0000);
        run_op("b2b_sub", 32'hA,  32'h3,  4'b0011, 32'h7,  4'b0001);
        step();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got out_valid=%b expected 0", ov32);
        end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        drive32(32'h3, 32'h5, 4'b1000);
        step();
        iv32 = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({ov32, o32, f32} !== {1'b0, 32'h0, 4'b0000}) begin
            errors++;
            $display("FAIL mid_mul_reset got valid=%b out=%h f=%b expected 0/00000000/0000",
                     ov32, o32, f32);
        end
        reset = 1'b1;
        step();
        checks++;
        if (ir32 !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_ready got in_ready=%b expected 1", ir32);
        end
        stray = 0;
        repeat (40) begin
            if (ov32 !== 1'b0) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL mid_mul_abort got %0d valid cycles expected 0", stray);
        end
        run_op("post_reset_add", 32'h2, 32'h2, 4'b0010, 32'h4, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_slt();
        test_logic();
        test_mulu8();
        test_mulu32();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
